// File: rtl/data_sram_like_responder_pkg.sv
// Shared types for the SRAM-like data responder: access sizes, response entry, byte-lane merge.
package data_sram_like_responder_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef struct packed {
      logic        is_load;
      size_e       size;
      logic [31:0] rdata;
   } resp_entry_t;

   localparam int unsigned RESP_W = $bits(resp_entry_t);

   // Replace only the byte lanes enabled in strb.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/data_sram_like_responder_resp_fifo.sv
// In-order response queue; each entry carries a saturating countdown until it may be answered.
module data_sram_like_responder_resp_fifo
   import data_sram_like_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LAT   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  resp_entry_t              push_entry,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     head_ready_c,
   output resp_entry_t              head_entry_c
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned TIMER_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(LAT - 1);

   logic [RESP_W-1:0]  entry_q [DEPTH];
   logic [TIMER_W-1:0] timer_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   // Payload storage needs no reset: validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) entry_q[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (push && (PTR_W'(i) == wr_ptr)) begin
            timer_q[i] <= TIMER_INIT;
         end else if (timer_q[i] != '0) begin
            timer_q[i] <= timer_q[i] - TIMER_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_ready_c = (count != '0) && (timer_q[rd_ptr] == '0);
   assign head_entry_c = resp_entry_t'(entry_q[rd_ptr]);

endmodule

// File: rtl/data_sram_like_responder.sv
// Target end of the SRAM-like data interface: word memory plus in-order delayed responses.
module data_sram_like_responder
   import data_sram_like_responder_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned LAT         = 2,
   parameter int unsigned OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   input  logic        addr_stall,
   input  logic        resp_stall
);

   localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;
   localparam int unsigned WORDS = 2 ** ADDR_W;

   logic [31:0]       mem [WORDS];
   logic              reset_q;
   logic [CNT_W-1:0]  count;
   logic              head_ready;
   resp_entry_t       head_entry;
   resp_entry_t       push_entry;
   logic              accept;
   logic              pop;
   logic [ADDR_W-1:0] idx;
   logic              unused_ok;

   assign idx = addr[ADDR_W+1:2];

   // Acceptance depends only on registered state; a same-cycle pop does not free a slot early.
   assign addr_ok = !reset_q && !addr_stall && (count < CNT_W'(OUTSTANDING));
   assign accept  = req && addr_ok && !reset;
   assign pop     = head_ready && !resp_stall && !reset;

   assign push_entry.is_load = !wr;
   assign push_entry.size    = size_e'(size);
   assign push_entry.rdata   = wr ? 32'h0 : mem[idx];

   always_ff @(posedge clk) begin
      reset_q <= reset;
   end

   // Memory is deliberately left uninitialised across reset.
   always_ff @(posedge clk) begin
      if (accept && wr) mem[idx] <= merge_bytes(mem[idx], wdata, wstrb);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_ok <= 1'b0;
         rdata   <= 32'h0;
      end else begin
         data_ok <= pop;
         rdata   <= (pop && head_entry.is_load) ? head_entry.rdata : 32'h0;
      end
   end

   data_sram_like_responder_resp_fifo #(
      .DEPTH (OUTSTANDING),
      .LAT   (LAT)
   ) u_resp_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (accept),
      .push_entry   (push_entry),
      .pop          (pop),
      .count        (count),
      .head_ready_c (head_ready),
      .head_entry_c (head_entry)
   );

   // Address bits outside the word index and the recorded size have no effect on behaviour.
   assign unused_ok = ^{addr[31:ADDR_W+2], addr[1:0], 2'(head_entry.size)};

endmodule

// File: tb/tb_data_sram_like_responder.sv
// Directed and randomized checks of the SRAM-like responder against an in-bench transaction model.
module tb_data_sram_like_responder;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned LAT    = 2;
   localparam int unsigned OUTS   = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_stall;
   logic        resp_stall;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;

   data_sram_like_responder #(
      .ADDR_W      (ADDR_W),
      .LAT         (LAT),
      .OUTSTANDING (OUTS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .wr         (wr),
      .size       (size),
      .addr       (addr),
      .wstrb      (wstrb),
      .wdata      (wdata),
      .addr_ok    (addr_ok),
      .data_ok    (data_ok),
      .rdata      (rdata),
      .addr_stall (addr_stall),
      .resp_stall (resp_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: a queue of accepted requests, each answerable LAT edges after acceptance.
   typedef struct {
      bit          is_load;
      logic [31:0] data;
      longint      t_acc;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mmem [2**ADDR_W];
   longint      cyc      = 0;
   bit          m_rst_q  = 1'b1;
   bit          exp_dok  = 1'b0;
   logic [31:0] exp_rd   = 32'h0;
   bit          last_rst = 1'b0;
   bit          started  = 1'b0;

   always @(posedge clk) begin
      bit          acc;
      int unsigned idx;
      ent_t        e;
      cyc++;
      started = 1'b1;
      if (reset) begin
         mq.delete();
         m_rst_q  = 1'b1;
         exp_dok  = 1'b0;
         exp_rd   = 32'h0;
         last_rst = 1'b1;
      end else begin
         acc = req && !m_rst_q && !addr_stall && (mq.size() < OUTS);
         exp_dok = 1'b0;
         if (mq.size() > 0 && (cyc - mq[0].t_acc) >= LAT && !resp_stall) begin
            exp_dok = 1'b1;
            exp_rd  = mq[0].is_load ? mq[0].data : 32'h0;
            void'(mq.pop_front());
         end
         if (acc) begin
            idx       = int'(addr[ADDR_W+1:2]);
            e.is_load = !wr;
            e.data    = mmem[idx];
            e.t_acc   = cyc;
            if (wr) begin
               for (int b = 0; b < 4; b++)
                  if (wstrb[b]) mmem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
            mq.push_back(e);
         end
         m_rst_q  = 1'b0;
         last_rst = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("addr_ok", 32'(addr_ok), 32'(!m_rst_q && !addr_stall && (mq.size() < OUTS)));
         chk("data_ok", 32'(data_ok), 32'(exp_dok));
         if (exp_dok)  chk("rdata", rdata, exp_rd);
         if (last_rst) chk("rdata_reset", rdata, 32'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output bit ok);
      req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (addr_ok) ok = 1'b1;
         tick();
      end
      req = 1'b0;
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic transact(input bit w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd, output int lat);
      bit ok;
      bit seen;
      issue(w, a, s, d, ok);
      lat  = 0;
      seen = 1'b0;
      rd   = 32'hx;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (data_ok) begin
            seen = 1'b1;
            rd   = rdata;
         end else begin
            lat++;
         end
         tick();
      end
      if (!seen) chk("data_ok_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] rd2;
      int          lat;
      int          n_acc;
      int          n_dok;
      int          first;
      int          last;
      bit          ok;

      reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; addr = 32'h0;
      wstrb = 4'h0; wdata = 32'h0; addr_stall = 1'b0; resp_stall = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Give the low words known contents so random loads have defined data.
      for (int i = 0; i < 64; i++) issue(1'b1, 32'(i * 4), 4'hF, $urandom, ok);
      idle(10);

      // Word store then load
      transact(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, rd, lat);
      chk("t1_store_lat", 32'(lat), 32'd2);
      chk("t1_store_rdata", rd, 32'h0);
      transact(1'b0, 32'h1000, 4'h0, 32'h0, rd, lat);
      chk("t1_load_lat", 32'(lat), 32'd2);
      chk("t1_load_rdata", rd, 32'hDEADBEEF);

      // Byte-lane merge
      transact(1'b1, 32'h1000, 4'hF, 32'h11223344, rd, lat);
      transact(1'b1, 32'h1003, 4'h8, 32'hAA000000, rd, lat);
      transact(1'b0, 32'h1000, 4'h0, 32'h0, rd, lat);
      chk("t2_byte_merge", rd, 32'hAA223344);

      // Full queue under response stall, then drain
      resp_stall = 1'b1;
      req = 1'b1; wr = 1'b0; addr = 32'h1000; wstrb = 4'h0;
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (addr_ok) n_acc++;
         tick();
      end
      chk("t3_accepts_when_full", 32'(n_acc), 32'd4);
      req = 1'b0; resp_stall = 1'b0;
      n_dok = 0; first = -1; last = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (data_ok) begin
            n_dok++;
            if (first < 0) first = i;
            last = i;
         end
         tick();
      end
      chk("t3_drain_count", 32'(n_dok), 32'd4);
      chk("t3_back_to_back", 32'(last - first), 32'd3);

      // Address stall blocks acceptance
      addr_stall = 1'b1;
      req = 1'b1; wr = 1'b0; addr = 32'h0;
      n_acc = 0; n_dok = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (addr_ok) n_acc++;
         if (data_ok) n_dok++;
         tick();
      end
      chk("t4_no_accept", 32'(n_acc), 32'd0);
      chk("t4_no_data_ok", 32'(n_dok), 32'd0);
      addr_stall = 1'b0;
      transact(1'b0, 32'h1000, 4'h0, 32'h0, rd, lat);
      chk("t4_after_release", rd, 32'hAA223344);

      // Reset with pending entries; memory survives
      transact(1'b1, 32'h2008, 4'hF, 32'h5555AAAA, rd, lat);
      resp_stall = 1'b1;
      for (int i = 0; i < 3; i++) issue(1'b0, 32'h2008, 4'h0, 32'h0, ok);
      reset = 1'b1;
      idle(2);
      reset = 1'b0; resp_stall = 1'b0;
      n_dok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (data_ok) n_dok++;
         tick();
      end
      chk("t5_flushed", 32'(n_dok), 32'd0);
      transact(1'b0, 32'h2008, 4'h0, 32'h0, rd, lat);
      chk("t5_mem_kept", rd, 32'h5555AAAA);
      chk("t5_lat", 32'(lat), 32'd2);

      // Index aliasing above the memory size
      transact(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, rd, lat);
      transact(1'b0, 32'h0, 4'h0, 32'h0, rd, lat);
      transact(1'b0, 32'h1000, 4'h0, 32'h0, rd2, lat);
      chk("t6_load_0", rd, 32'hCAFEF00D);
      chk("t6_load_alias", rd2, 32'hCAFEF00D);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         req        = ($urandom % 3) != 0;
         wr         = $urandom % 2;
         size       = 2'($urandom % 3);
         addr       = ($urandom & 32'hFFFFF000) | ((($urandom % 64)) << 2) | ($urandom % 4);
         wstrb      = 4'($urandom);
         wdata      = $urandom;
         addr_stall = ($urandom % 8) == 0;
         resp_stall = ($urandom % 5) == 0;
         reset      = ($urandom % 500) == 0;
         tick();
      end
      req = 1'b0; reset = 1'b0; addr_stall = 1'b0; resp_stall = 1'b0;
      idle(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
